// File: rtl/toggle_cover_detect_if.sv
// toggle_cover_detect_if
//   Index stream carrying newly covered toggle points out of toggle_cover_detect.
//   evt_valid  producer -> consumer   index available
//   evt_ready  consumer -> producer   consumer accepts when evt_valid & evt_ready
//   evt_index  producer -> consumer   global cover point index (32 bits)
interface toggle_cover_detect_if;
  logic        evt_valid;
  logic        evt_ready;
  logic [31:0] evt_index;

  modport master (output evt_valid, output evt_index, input evt_ready);
  modport slave  (input evt_valid, input evt_index, output evt_ready);
endinterface

// File: rtl/toggle_cover_detect.sv
// toggle_cover_detect
//   Samples a WIDTH-bit probe and tracks rising/falling edges per bit in sticky
//   bitmaps. A bit is covered once both edge directions have been seen; each
//   newly covered bit pulses valid[i] for one cycle and is queued for the serial
//   index stream (lowest bit number first).
//
//   Optional build macro: TOGGLE_COVER_ANY_EDGE_EN -- a bit is covered on its
//   first edge of either direction instead of needing both.
//
// Ports
//   clock        in   sole clock, all state on posedge
//   reset        in   asynchronous active-low reset
//   clear        in   synchronous clear of all coverage state (beats en/drain)
//   en           in   sample enable
//   probe        in   [WIDTH]  signal under toggle coverage
//   valid        out  [WIDTH]  one-cycle pulse per newly covered bit
//   covered_cnt  out  number of points covered since reset/clear
//   all_covered  out  covered_cnt == WIDTH
//   evt          master modport of toggle_cover_detect_if (index stream)
module toggle_cover_detect #(
  parameter int unsigned WIDTH       = 58,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 8744
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       en,
  input  logic [WIDTH-1:0]           probe,
  output logic [WIDTH-1:0]           valid,
  output logic [$clog2(WIDTH+1)-1:0] covered_cnt,
  output logic                       all_covered,
  toggle_cover_detect_if.master      evt
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // The global index range of this instance must lie within the design total.
  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_cfg_check
    $error("toggle_cover_detect: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_ok_q, prev_ok_d;
  logic [WIDTH-1:0] seen_rise_q, seen_rise_d;
  logic [WIDTH-1:0] seen_fall_q, seen_fall_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_valid_q, evt_valid_d;
  logic [31:0]      evt_index_q, evt_index_d;

  logic [WIDTH-1:0] rise, fall;
  logic [WIDTH-1:0] done_cur, done_nxt, new_done;
  logic [WIDTH-1:0] drain_sel;
  logic [31:0]      low_idx;
  logic             found;
  logic             drain_ok;
  logic [CNT_W-1:0] new_cnt;

  always_comb begin
    rise = '0;
    fall = '0;
    if (en && prev_ok_q) begin
      rise = probe & ~prev_q;
      fall = ~probe & prev_q;
    end
    seen_rise_d = seen_rise_q | rise;
    seen_fall_d = seen_fall_q | fall;

`ifdef TOGGLE_COVER_ANY_EDGE_EN
    done_cur = seen_rise_q | seen_fall_q;
    done_nxt = seen_rise_d | seen_fall_d;
`else
    done_cur = seen_rise_q & seen_fall_q;
    done_nxt = seen_rise_d & seen_fall_d;
`endif
    new_done = done_nxt & ~done_cur;

    new_cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      new_cnt = new_cnt + CNT_W'(new_done[i]);
    end

    // Lowest pending bit is drained first.
    found     = 1'b0;
    low_idx   = '0;
    drain_sel = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && pending_q[i]) begin
        found        = 1'b1;
        low_idx      = i;
        drain_sel[i] = 1'b1;
      end
    end
    drain_ok = (!evt_valid_q || evt.evt_ready) && found;

    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    if (en) begin
      prev_d    = probe;
      prev_ok_d = 1'b1;
    end

    valid_d = new_done;
    cnt_d   = cnt_q + new_cnt;

    // A bit enters pending once per clear epoch, so the drained bit never
    // collides with a newly done one.
    pending_d = (pending_q & ~(drain_ok ? drain_sel : '0)) | new_done;

    if (drain_ok) begin
      evt_valid_d = 1'b1;
      evt_index_d = COVER_INDEX + low_idx;
    end else begin
      evt_valid_d = evt_valid_q & ~evt.evt_ready;
      evt_index_d = evt_index_q;
    end

    if (clear) begin
      prev_d      = '0;
      prev_ok_d   = 1'b0;
      seen_rise_d = '0;
      seen_fall_d = '0;
      pending_d   = '0;
      valid_d     = '0;
      cnt_d       = '0;
      evt_valid_d = 1'b0;
      evt_index_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
      seen_rise_q <= '0;
      seen_fall_q <= '0;
      pending_q   <= '0;
      valid_q     <= '0;
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_index_q <= '0;
    end else begin
      prev_q      <= prev_d;
      prev_ok_q   <= prev_ok_d;
      seen_rise_q <= seen_rise_d;
      seen_fall_q <= seen_fall_d;
      pending_q   <= pending_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_index_q <= evt_index_d;
    end
  end

  assign valid         = valid_q;
  assign covered_cnt   = cnt_q;
  assign all_covered   = (cnt_q == CNT_W'(WIDTH));
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_index = evt_index_q;

endmodule

// File: tb/tb_toggle_cover_detect.sv
// tb_toggle_cover_detect
//   Directed vectors for toggle_cover_detect with hand-computed expectations.
module tb_toggle_cover_detect;

  localparam int unsigned W  = 58;
  localparam int unsigned CI = 100;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clock;
  logic          reset;
  logic          clear;
  logic          en;
  logic [W-1:0]  probe;
  logic [W-1:0]  valid;
  logic [CW-1:0] covered_cnt;
  logic          all_covered;

  int unsigned n_checks;
  int unsigned n_pass;

  toggle_cover_detect_if evt_bus();

  toggle_cover_detect #(
    .WIDTH      (W),
    .COVER_INDEX(CI),
    .COVER_TOTAL(8744)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .en         (en),
    .probe      (probe),
    .valid      (valid),
    .covered_cnt(covered_cnt),
    .all_covered(all_covered),
    .evt        (evt_bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Inputs set before tick are sampled at that edge; outputs read after tick
  // reflect that edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    en    = 1'b0;
    probe = '0;
    evt_bus.evt_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  logic [W-1:0] ones;
  logic [W-1:0] m;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    ones     = '1;
    reset    = 1'b0;
    clear    = 1'b0;
    en       = 1'b0;
    probe    = '0;
    evt_bus.evt_ready = 1'b0;
    #12;

    // ---- 1: reset values, then single bit0 toggle
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_evt_valid", 64'(evt_bus.evt_valid), 64'd0);
    check("rst_evt_index", 64'(evt_bus.evt_index), 64'd0);
    check("rst_cnt", 64'(covered_cnt), 64'd0);
    check("rst_all", 64'(all_covered), 64'd0);
    do_reset();
    en = 1'b1; probe = '0; tick();
    probe = W'(1); tick();
    check("t1_rise_no_valid", 64'(valid), 64'd0);
    probe = '0; tick();
    check("t1_valid", 64'(valid), 64'd1);
    check("t1_cnt", 64'(covered_cnt), 64'd1);
    tick();
    check("t1_valid_one_cycle", 64'(valid), 64'd0);
    check("t1_evt_valid", 64'(evt_bus.evt_valid), 64'd1);
    check("t1_evt_index", 64'(evt_bus.evt_index), 64'(CI));
    evt_bus.evt_ready = 1'b1; tick();
    check("t1_evt_drained", 64'(evt_bus.evt_valid), 64'd0);

    // ---- 2: first sample all-ones detects nothing; full toggle covers all
    do_reset();
    en = 1'b1; probe = ones; tick();
    check("t2_first_valid", 64'(valid), 64'd0);
    tick();
    check("t2_first_valid2", 64'(valid), 64'd0);
    check("t2_first_evt", 64'(evt_bus.evt_valid), 64'd0);
    probe = '0; tick();
    check("t2_fall_valid", 64'(valid), 64'd0);
    probe = ones; evt_bus.evt_ready = 1'b1; tick();
    check("t2_valid_all", 64'(valid), 64'(ones));
    check("t2_cnt", 64'(covered_cnt), 64'(W));
    check("t2_all_cov", 64'(all_covered), 64'd1);
    for (int k = 0; k < W; k++) begin
      tick();
      check("t2_stream_index", 64'(evt_bus.evt_index), 64'(CI + k));
      check("t2_stream_valid", 64'(evt_bus.evt_valid), 64'd1);
    end
    check("t2_valid_gone", 64'(valid), 64'd0);
    tick();
    check("t2_stream_empty", 64'(evt_bus.evt_valid), 64'd0);

    // ---- 3: bits 3,7,40 together, backpressure for 5 cycles
    do_reset();
    m = '0; m[3] = 1'b1; m[7] = 1'b1; m[40] = 1'b1;
    en = 1'b1; probe = '0; tick();
    probe = m; tick();
    probe = '0; tick();
    check("t3_valid", 64'(valid), 64'(m));
    check("t3_cnt", 64'(covered_cnt), 64'd3);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_hold_valid", 64'(evt_bus.evt_valid), 64'd1);
      check("t3_hold_index", 64'(evt_bus.evt_index), 64'(CI + 3));
    end
    evt_bus.evt_ready = 1'b1; tick();
    check("t3_idx7", 64'(evt_bus.evt_index), 64'(CI + 7));
    tick();
    check("t3_idx40", 64'(evt_bus.evt_index), 64'(CI + 40));
    check("t3_idx40_valid", 64'(evt_bus.evt_valid), 64'd1);
    tick();
    check("t3_empty", 64'(evt_bus.evt_valid), 64'd0);

    // ---- 4: clear with evt outstanding and bit5 pending
    do_reset();
    m = '0; m[4] = 1'b1; m[5] = 1'b1;
    en = 1'b1; probe = '0; tick();
    probe = m; tick();
    probe = '0; tick();
    tick();
    check("t4_pre_evt", 64'(evt_bus.evt_valid), 64'd1);
    check("t4_pre_index", 64'(evt_bus.evt_index), 64'(CI + 4));
    clear = 1'b1; tick();
    clear = 1'b0;
    check("t4_clr_evt", 64'(evt_bus.evt_valid), 64'd0);
    check("t4_clr_cnt", 64'(covered_cnt), 64'd0);
    evt_bus.evt_ready = 1'b1; tick();
    check("t4_no_pending", 64'(evt_bus.evt_valid), 64'd0);
    m = '0; m[5] = 1'b1;
    probe = m; tick();
    probe = '0; tick();
    check("t4_retoggle_valid", 64'(valid), 64'(m));
    check("t4_retoggle_cnt", 64'(covered_cnt), 64'd1);
    tick();
    check("t4_retoggle_index", 64'(evt_bus.evt_index), 64'(CI + 5));
    check("t4_retoggle_evt", 64'(evt_bus.evt_valid), 64'd1);

    // ---- 5: single rise on bit2; en low freezes sampling
    do_reset();
    m = '0; m[2] = 1'b1;
    en = 1'b1; probe = '0; tick();
    probe = m; tick();
`ifdef TOGGLE_COVER_ANY_EDGE_EN
    check("t5_valid", 64'(valid), 64'(m));
    check("t5_cnt", 64'(covered_cnt), 64'd1);
`else
    check("t5_valid", 64'(valid), 64'd0);
    check("t5_cnt", 64'(covered_cnt), 64'd0);
`endif
    en = 1'b0; probe = '0; tick();
    check("t5_en_low_valid", 64'(valid), 64'd0);
    tick();
`ifdef TOGGLE_COVER_ANY_EDGE_EN
    check("t5_en_low_cnt", 64'(covered_cnt), 64'd1);
`else
    check("t5_en_low_cnt", 64'(covered_cnt), 64'd0);
`endif

    // ---- 6: async reset mid-stream
    do_reset();
    m = '0; m[1] = 1'b1; m[2] = 1'b1;
    en = 1'b1; probe = '0; tick();
    probe = m; tick();
    probe = '0; tick();
    check("t6_pre_cnt", 64'(covered_cnt), 64'd2);
    tick();
    check("t6_pre_evt", 64'(evt_bus.evt_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_evt_valid", 64'(evt_bus.evt_valid), 64'd0);
    check("t6_async_evt_index", 64'(evt_bus.evt_index), 64'd0);
    check("t6_async_cnt", 64'(covered_cnt), 64'd0);
    check("t6_async_all", 64'(all_covered), 64'd0);
    check("t6_async_valid", 64'(valid), 64'd0);
    #2;
    reset = 1'b1;
    tick();
    check("t6_after_evt", 64'(evt_bus.evt_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
